mux4_word_sequencer: RTL

- Upstream driver for the 4:1 mux stage (2-bit select, 4-bit data word, 1-bit output).
- Accepts a 4-bit word over a valid/ready handshake, holds it on the mux data lines, and steps the select through all four channels with a programmable dwell per channel.
- The downstream mux output therefore emits the word as a serial bit stream.
- Provides busy, per-bit strobe and end-of-word pulse for the consumer of the mux output.

---
 rtl/mux4_word_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/mux4_word_sequencer.sv
// Purpose: serialises a 4-bit word through a downstream 4:1 mux by holding the word on w and stepping the select s across all four channels.
// Latency: 4*DWELL cycles from the accept edge to the edge after done; each channel is held for exactly DWELL cycles.
// Backpressure: in_ready is high in IDLE and on the final cycle of a word, which allows back-to-back words; abort forces in_ready low.
module mux4_word_sequencer #(
    parameter int unsigned DWELL     = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       abort,
    output logic [1:0] s,
    output logic [3:0] w,
    output logic       busy,
    output logic       bit_strobe,
    output logic       done
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [7:0] DCNT_LAST = 8'(DWELL - 1);
    localparam logic [1:0] S_FIRST   = MSB_FIRST ? 2'd3 : 2'd0;
    localparam logic [1:0] S_LAST    = MSB_FIRST ? 2'd0 : 2'd3;

    state_t     state_q;
    logic [7:0] dcnt_q;
    logic [1:0] s_q;
    logic [3:0] w_q;
    logic       busy_q;
    logic       strobe_q;

    logic       last_cycle;
    logic       accept;
    logic [1:0] s_step_d;

    // Decode the final cycle of a word, the handshake and the next channel.
    always_comb begin
        last_cycle = (state_q == SEND) && (dcnt_q == DCNT_LAST) && (s_q == S_LAST);
        in_ready   = !abort && ((state_q == IDLE) || last_cycle);
        done       = last_cycle && !abort;
        accept     = in_valid && in_ready;
        s_step_d   = MSB_FIRST ? (s_q - 2'd1) : (s_q + 2'd1);
    end

    // Sequencer FSM: abort beats everything, an accept restarts the word, otherwise dwell and step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dcnt_q   <= 8'd0;
            s_q      <= 2'b00;
            w_q      <= 4'b0000;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else if ((state_q == SEND) && abort) begin
            state_q  <= IDLE;
            dcnt_q   <= 8'd0;
            s_q      <= 2'b00;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else if (accept) begin
            state_q  <= SEND;
            dcnt_q   <= 8'd0;
            s_q      <= S_FIRST;
            w_q      <= in_data;
            busy_q   <= 1'b1;
            strobe_q <= 1'b1;
        end else if (state_q == SEND) begin
            if (dcnt_q != DCNT_LAST) begin
                dcnt_q   <= dcnt_q + 8'd1;
                strobe_q <= 1'b0;
            end else if (s_q != S_LAST) begin
                s_q      <= s_step_d;
                dcnt_q   <= 8'd0;
                strobe_q <= 1'b1;
            end else begin
                // Word finished with nothing queued: park the select, keep the last word on w.
                state_q  <= IDLE;
                dcnt_q   <= 8'd0;
                s_q      <= 2'b00;
                busy_q   <= 1'b0;
                strobe_q <= 1'b0;
            end
        end
    end

    assign s          = s_q;
    assign w          = w_q;
    assign busy       = busy_q;
    assign bit_strobe = strobe_q;

endmodule
